// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a synchronous FIFO and re-presents words on a valid/ready stream.
// Optional packet framing via m_last is enabled by defining FIFO_RD_LAST_EN.
module fifo_stream_reader #(
    parameter int DSIZE   = 32,
    parameter int PKT_LEN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DSIZE-1:0] fifo_rdata,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [31:0]      beat_total
);

    typedef logic [1:0] idx_t;

    logic [DSIZE-1:0] skid_q [3];
    idx_t             head;
    idx_t             tail;
    logic [1:0]       occ;
    logic             inflight;
    logic [2:0]       credit;
    logic             accept;

    function automatic idx_t idx_next(input idx_t i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign credit    = {1'b0, occ} + {2'b0, inflight};
    assign fifo_rinc = rst_n && enable && !fifo_rempty && (credit < 3'd3);
    assign m_valid   = (occ != 2'd0);
    assign m_data    = skid_q[head];
    assign accept    = m_valid && m_ready;

    // Skid buffer: capture landing read data at tail, retire accepted beats at head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                skid_q[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rinc;
            if (inflight) begin
                skid_q[tail] <= fifo_rdata;
                tail         <= idx_next(tail);
            end
            if (accept) begin
                head <= idx_next(head);
            end
            case ({inflight, accept})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Running count of accepted beats, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_total <= '0;
        end else if (accept) begin
            beat_total <= beat_total + 32'd1;
        end
    end

`ifdef FIFO_RD_LAST_EN
    localparam logic [15:0] PKT_LAST = 16'(PKT_LEN - 1);

    logic [15:0] pkt_cnt;

    // Beat position within the current packet, wrapping after the last beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (accept) begin
            pkt_cnt <= (pkt_cnt == PKT_LAST) ? 16'd0 : pkt_cnt + 16'd1;
        end
    end

    assign m_last = m_valid && (pkt_cnt == PKT_LAST);
`else
    // Framing off: never asserts for any legal PKT_LEN.
    assign m_last = m_valid && (PKT_LEN == 0);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench for fifo_stream_reader with a behavioural FIFO.
// Expected words are queued at write time and checked by an independent monitor.
module tb_fifo_stream_reader;

    localparam int DSIZE   = 32;
    localparam int PKT_LEN = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             m_ready = 1'b0;
    logic [DSIZE-1:0] fifo_rdata = '0;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic [31:0]      beat_total;

    fifo_stream_reader #(
        .DSIZE  (DSIZE),
        .PKT_LEN(PKT_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_rdata (fifo_rdata),
        .fifo_rempty(fifo_rempty),
        .fifo_rinc  (fifo_rinc),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .beat_total (beat_total)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous FIFO: registered rdata updated only on a pop.
    logic [DSIZE-1:0] fmem [4096];
    int               wptr = 0;
    int               rptr = 0;
    logic             wr_en = 1'b0;
    logic [DSIZE-1:0] wr_data = '0;

    assign fifo_rempty = (wptr == rptr);

    always @(posedge clk) begin
        if (wr_en) begin
            fmem[wptr % 4096] <= wr_data;
            wptr <= wptr + 1;
        end
        if (fifo_rinc && !fifo_rempty) begin
            fifo_rdata <= fmem[rptr % 4096];
            rptr <= rptr + 1;
        end
    end

    typedef struct packed {
        logic [DSIZE-1:0] d;
        logic             l;
    } exp_t;

    exp_t sb_q[$];
    int   exp_idx = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pop_cnt = 0;
    int   acc_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DSIZE-1:0] w);
        exp_t e;
        e.d = w;
`ifdef FIFO_RD_LAST_EN
        e.l = ((exp_idx % PKT_LEN) == PKT_LEN - 1);
`else
        e.l = 1'b0;
`endif
        exp_idx++;
        sb_q.push_back(e);
    endtask

    task automatic write_word(input logic [DSIZE-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        push_word(w);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((sb_q.size() != 0 || m_valid || !fifo_rempty) && n < 300) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk({nm, "_left"}, 64'(sb_q.size()), 0);
    endtask

    task automatic reset_checked(input string nm);
        rst_n = 1'b0;
        tick();
        chk({nm, "_rinc"}, fifo_rinc, 0);
        chk({nm, "_valid"}, m_valid, 0);
        chk({nm, "_data"}, m_data, 0);
        chk({nm, "_last"}, m_last, 0);
        chk({nm, "_total"}, beat_total, 0);
        sb_q.delete();
        exp_idx = 0;
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: scoreboard pops, hold-under-stall and structural invariants.
    logic             prev_stall = 1'b0;
    logic [DSIZE-1:0] prev_data = '0;
    always @(negedge clk) begin
        exp_t e;
        logic credit_ok;
        if (fifo_rinc) pop_cnt++;
        chk("pop_while_empty", fifo_rinc && fifo_rempty, 0);
        credit_ok = ({1'b0, dut.occ} + {2'b0, dut.inflight}) <= 3'd3;
        chk("credit_le_3", credit_ok, 1);
        if (rst_n && prev_stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_data);
        end
        if (rst_n && m_valid && m_ready) begin
            acc_cnt++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL extra_beat: got %0h expected none", m_data);
            end else begin
                e = sb_q.pop_front();
                chk("beat_data", m_data, e.d);
                chk("beat_last", m_last, e.l);
            end
        end
        prev_stall = rst_n && m_valid && !m_ready;
        prev_data  = m_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int a0;
        int n;
        int gaps;
        int sent;

        // Reset held while the FIFO fills with 5 words.
        rst_n   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) write_word(32'hA0 + 32'(i));
        tick();
        chk("rst_rinc", fifo_rinc, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_total", beat_total, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_rinc", fifo_rinc, 1);
        chk("rel_valid0", m_valid, 0);
        tick();
        chk("rel_valid1", m_valid, 0);
        tick();
        chk("rel_valid2", m_valid, 1);
        chk("rel_data2", m_data, 32'hA0);
        m_ready = 1'b1;
        drain("rst5");

        // Back-to-back streaming of 64 words.
        reset_checked("pre_stream");
        m_ready = 1'b1;
        fork
            begin
                for (int i = 1; i <= 64; i++) write_word(32'(i));
            end
            begin
                n = 0;
                while (!m_valid && n < 20) begin
                    tick();
                    n++;
                end
                chk("stream_latency", 64'(n), 3);
                gaps = 0;
                for (int k = 0; k < 64; k++) begin
                    if (!m_valid) gaps++;
                    tick();
                end
                chk("stream_gaps", 64'(gaps), 0);
            end
        join
        drain("stream");
        chk("stream_total", beat_total, 64);

        // Backpressure: 10 words, consumer stalled for 20 cycles.
        m_ready = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) write_word(32'hB00 + 32'(i));
        for (int i = 0; i < 10; i++) tick();
        chk("bp_pops", 64'(pop_cnt - p0), 3);
        chk("bp_valid", m_valid, 1);
        chk("bp_head", m_data, 32'hB00);
        m_ready = 1'b1;
        drain("bp");
        chk("bp_pops_total", 64'(pop_cnt - p0), 10);
        chk("bp_total", beat_total, 74);

        // Random writes against a random consumer.
        sent = 0;
        while (sent < 1000) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                write_word($urandom);
                sent++;
            end else begin
                tick();
            end
        end
        m_ready = 1'b1;
        drain("rand");
        chk("rand_total", beat_total, 1074);

        // Enable gating mid-stream.
        enable = 1'b0;
        p0 = pop_cnt;
        for (int i = 0; i < 6; i++) write_word(32'hC00 + 32'(i));
        chk("en_off_pops", 64'(pop_cnt - p0), 0);
        a0 = acc_cnt;
        enable = 1'b1;
        tick();
        tick();
        tick();
        chk("en_on_pops", 64'(pop_cnt - p0), 3);
        enable = 1'b0;
        #1;
        chk("en_drop_rinc", fifo_rinc, 0);
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) tick();
        chk("en_low_pops", 64'(pop_cnt - p0), 0);
        chk("en_low_beats", 64'(acc_cnt - a0), 3);
        enable = 1'b1;
        drain("en");
        chk("en_beats", 64'(acc_cnt - a0), 6);

        // Packet framing, then a reset in the middle of a packet.
        reset_checked("pre_pkt");
        m_ready = 1'b1;
        for (int i = 0; i < 14; i++) write_word(32'hD00 + 32'(i));
        drain("pkt");
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(32'hE00 + 32'(i));
        for (int i = 0; i < 6; i++) tick();
        chk("pkt_full_valid", m_valid, 1);
        reset_checked("mid_pkt");
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) write_word(32'hF00 + 32'(i));
        drain("post_rst");
        chk("post_rst_total", beat_total, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
